// File: rtl/elevator_pkg.sv
// Shared types and constants for the 4-floor elevator scheduler.
package elevator_pkg;

    localparam int NUM_FLOORS = 4;

    typedef logic [1:0] floor_t;

    localparam floor_t FLOOR0 = 2'd0;
    localparam floor_t FLOOR1 = 2'd1;
    localparam floor_t FLOOR2 = 2'd2;
    localparam floor_t FLOOR3 = 2'd3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR      = 2'd3
    } sched_state_t;

    function automatic logic [NUM_FLOORS-1:0] floor_onehot(input floor_t f);
        return {{(NUM_FLOORS-1){1'b0}}, 1'b1} << f;
    endfunction

endpackage

// File: rtl/elevator_target_sel.sv
// Priority scan over the pending-call register: nearest pending floor
// strictly above and strictly below the current floor.
module elevator_target_sel
    import elevator_pkg::*;
(
    input  logic [NUM_FLOORS-1:0] i_pending,
    input  floor_t                i_floor,
    output logic                  o_any_above,
    output logic                  o_any_below,
    output floor_t                o_next_above,
    output floor_t                o_next_below
);

    logic w_hit;

    // Downward scan for "above" and upward scan for "below" so the nearest floor wins.
    always_comb begin
        o_any_above  = 1'b0;
        o_any_below  = 1'b0;
        o_next_above = i_floor;
        o_next_below = i_floor;
        w_hit        = 1'b0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            w_hit        = i_pending[i] && (i > int'(i_floor));
            o_any_above  = o_any_above | w_hit;
            o_next_above = w_hit ? floor_t'(i) : o_next_above;
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            w_hit        = i_pending[i] && (i < int'(i_floor));
            o_any_below  = o_any_below | w_hit;
            o_next_below = w_hit ? floor_t'(i) : o_next_below;
        end
    end

endmodule

// File: rtl/elevator_scheduler.sv
// Collective-control SCAN scheduler: latches floor calls, steers the
// elevator FSM via target/stop, and times the door dwell.
module elevator_scheduler #(
    parameter int NUM_FLOORS   = 4,
    parameter int DWELL_CYCLES = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [NUM_FLOORS-1:0] i_call_req,
    input  logic                  i_hold,
    input  logic [1:0]            i_floor,
    output logic [1:0]            o_target,
    output logic                  o_stop,
    output logic                  o_door_open,
    output logic                  o_dir_up,
    output logic [NUM_FLOORS-1:0] o_pending
);
    import elevator_pkg::*;

    localparam int DW = $clog2(DWELL_CYCLES + 1);
    localparam logic [DW-1:0] DWELL_LOAD = DW'(DWELL_CYCLES - 1);

    sched_state_t          r_state;
    logic [NUM_FLOORS-1:0] r_pending;
    logic                  r_dir_up;
    logic [DW-1:0]         r_dwell;

    sched_state_t          w_state_n;
    logic                  w_dir_n;
    logic [DW-1:0]         w_dwell_n;
    logic [NUM_FLOORS-1:0] w_pending_n;
    logic [NUM_FLOORS-1:0] w_floor_oh;
    logic                  w_here;
    logic                  w_any_above;
    logic                  w_any_below;
    floor_t                w_next_above;
    floor_t                w_next_below;
    floor_t                w_tgt_up;
    floor_t                w_tgt_down;

    elevator_target_sel u_target_sel (
        .i_pending    (r_pending),
        .i_floor      (i_floor),
        .o_any_above  (w_any_above),
        .o_any_below  (w_any_below),
        .o_next_above (w_next_above),
        .o_next_below (w_next_below)
    );

    assign w_floor_oh = floor_onehot(i_floor);
    assign w_here     = |(r_pending & w_floor_oh);
    // A pending call at the current floor pins the target so the car settles here.
    assign w_tgt_up   = w_here ? i_floor : (w_any_above ? w_next_above : i_floor);
    assign w_tgt_down = w_here ? i_floor : (w_any_below ? w_next_below : i_floor);
    assign o_dir_up   = r_dir_up;
    assign o_pending  = r_pending;

    // Outputs decoded from state, floor and pending; hold always forces a stop.
    always_comb begin
        o_target    = i_floor;
        o_stop      = 1'b1;
        o_door_open = 1'b0;
        case (r_state)
            MOVE_UP: begin
                o_target = w_tgt_up;
                o_stop   = i_hold;
            end
            MOVE_DOWN: begin
                o_target = w_tgt_down;
                o_stop   = i_hold;
            end
            DOOR: begin
                o_door_open = 1'b1;
            end
            default: begin
                o_target = i_floor;
                o_stop   = 1'b1;
            end
        endcase
    end

    // Next-state, sweep direction and dwell counter; everything freezes under hold.
    always_comb begin
        w_state_n = r_state;
        w_dir_n   = r_dir_up;
        w_dwell_n = r_dwell;
        if (i_hold) begin
            w_state_n = r_state;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_here) begin
                        w_state_n = DOOR;
                        w_dwell_n = DWELL_LOAD;
                    end else if (w_any_above && w_any_below) begin
                        w_state_n = r_dir_up ? MOVE_UP : MOVE_DOWN;
                    end else if (w_any_above) begin
                        w_state_n = MOVE_UP;
                        w_dir_n   = 1'b1;
                    end else if (w_any_below) begin
                        w_state_n = MOVE_DOWN;
                        w_dir_n   = 1'b0;
                    end else begin
                        w_state_n = IDLE;
                    end
                end
                MOVE_UP: begin
                    if (w_here) begin
                        w_state_n = DOOR;
                        w_dwell_n = DWELL_LOAD;
                    end else if (!w_any_above) begin
                        w_state_n = IDLE;
                    end else begin
                        w_state_n = MOVE_UP;
                    end
                end
                MOVE_DOWN: begin
                    if (w_here) begin
                        w_state_n = DOOR;
                        w_dwell_n = DWELL_LOAD;
                    end else if (!w_any_below) begin
                        w_state_n = IDLE;
                    end else begin
                        w_state_n = MOVE_DOWN;
                    end
                end
                DOOR: begin
                    if (|(i_call_req & w_floor_oh)) begin
                        w_dwell_n = DWELL_LOAD;
                    end else if (r_dwell != {DW{1'b0}}) begin
                        w_dwell_n = r_dwell - DW'(1);
                    end else if (r_dir_up ? w_any_above : w_any_below) begin
                        w_state_n = r_dir_up ? MOVE_UP : MOVE_DOWN;
                    end else if (r_dir_up ? w_any_below : w_any_above) begin
                        w_state_n = r_dir_up ? MOVE_DOWN : MOVE_UP;
                        w_dir_n   = ~r_dir_up;
                    end else begin
                        w_state_n = IDLE;
                    end
                end
                default: begin
                    w_state_n = IDLE;
                end
            endcase
        end
        // Clear beats set: calls at the floor being serviced are absorbed.
        w_pending_n = (r_pending | i_call_req) &
                      ~((w_state_n == DOOR) ? w_floor_oh : {NUM_FLOORS{1'b0}});
    end

    // State, pending calls, direction and dwell registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_pending <= {NUM_FLOORS{1'b0}};
            r_dir_up  <= 1'b1;
            r_dwell   <= {DW{1'b0}};
        end else begin
            r_state   <= w_state_n;
            r_pending <= w_pending_n;
            r_dir_up  <= w_dir_n;
            r_dwell   <= w_dwell_n;
        end
    end

endmodule
